sync_fifo_param: RTL and testbench

Single-clock, parametrised FIFO: the next generation of the project's FIFO block, generalised in data width and depth. It adds an occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It sits between the `ui_in`/`uio_in` capture logic and the `uo_out` drive logic of the tile's top-level wrapper, and is reusable as a standalone buffer in any single-clock path.

---
 rtl/sync_fifo_param.sv | 128 ++++++++++++
 tb/tb_sync_fifo_param.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with an occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional feature macro: SYNC_FIFO_FWFT_EN selects first-word fall-through
// reads. When it is left undefined, reads are registered with a latency of
// one cycle.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg, count_next;
    logic             full_reg, empty_reg, almost_full_reg, almost_empty_reg;
    logic             overflow_reg, underflow_reg;
    logic             wr_acc, rd_acc;

    // Acceptance uses the registered flags only: no bypass when full or empty.
    assign wr_acc = wr_en & ~full_reg;
    assign rd_acc = rd_en & ~empty_reg;

    // Next occupancy: each accepted operation applied once per cycle.
    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers, count and occupancy flags registered from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            full_reg         <= 1'b0;
            empty_reg        <= 1'b1;
            almost_full_reg  <= (AF_LEVEL == 0);
            almost_empty_reg <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (rd_acc) rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg        <= count_next;
            full_reg         <= (count_next == DEPTH_C);
            empty_reg        <= (count_next == '0);
            almost_full_reg  <= (count_next >= AF_C);
            almost_empty_reg <= (count_next <= AE_C);
        end
    end

    // Sticky error flags; a fresh error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_en && full_reg)   overflow_reg <= 1'b1;
            else if (clr_err)        overflow_reg <= 1'b0;
            if (rd_en && empty_reg)  underflow_reg <= 1'b1;
            else if (clr_err)        underflow_reg <= 1'b0;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown combinationally; rd_en acknowledges it.
    assign rd_data  = mem[rd_ptr_reg];
    assign rd_valid = ~empty_reg;
`else
    logic [WIDTH-1:0] rd_data_reg;
    logic             rd_valid_reg;

    // Registered read: data loads on an accepted pop and holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_acc;
            if (rd_acc) rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
`endif

    assign full         = full_reg;
    assign empty        = empty_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2).
// A queue-based reference model predicts every output after each edge.
// Honours SYNC_FIFO_FWFT_EN when the bench is built with it.
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int AEL   = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_en = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid, full, empty, almost_full, almost_empty;
    logic [CW-1:0]    count;
    logic             overflow, underflow;

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_data = '0;
    logic             m_valid = 1'b0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    int errors = 0;
    int checks = 0;
    int step_no = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("almost_full", 32'(almost_full), 32'(n >= AFL));
        chk("almost_empty", 32'(almost_empty), 32'(n <= AEL));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        chk("rd_valid", 32'(rd_valid), 32'(n != 0));
        if (n != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
`else
        chk("rd_valid", 32'(rd_valid), 32'(m_valid));
        chk("rd_data", 32'(rd_data), 32'(m_data));
`endif
    endtask

    // One clock cycle: drive, advance the model from pre-edge occupancy, check.
    task automatic step(input logic r, input logic we, input logic [WIDTH-1:0] wd,
                        input logic re, input logic ce);
        bit was_full, was_empty;
        @(negedge clk);
        rst = r; wr_en = we; wr_data = wd; rd_en = re; clr_err = ce;
        @(posedge clk);
        step_no++;
        if (r) begin
            q.delete();
            m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            if (we && was_full) m_ovf = 1'b1;
            else if (ce)        m_ovf = 1'b0;
            if (re && was_empty) m_unf = 1'b1;
            else if (ce)         m_unf = 1'b0;
            m_valid = 1'b0;
            if (re && !was_empty) begin
                m_data  = q.pop_front();
                m_valid = 1'b1;
            end
            if (we && !was_full) q.push_back(wd);
        end
        #1;
        $display("step %0d rst=%0b we=%0b wd=%02h re=%0b ce=%0b -> count=%0d rd_valid=%0b rd_data=%02h ovf=%0b unf=%0b",
                 step_no, r, we, wd, re, ce, count, rd_valid, rd_data, overflow, underflow);
        check_all();
    endtask

    initial begin
        // Reset then idle
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 0);

        // Fill 0x01..0x08, one rejected write, full drain
        for (int i = 1; i <= 8; i++) step(0, 1, 8'(i), 0, 0);
        step(0, 1, 8'hFF, 0, 0);
        // Error event plus clear in the same cycle: overflow must stay set
        step(0, 1, 8'hEE, 0, 1);
        step(0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);

        // Fill to 4, then 20 simultaneous read/write cycles
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h10 + i), 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 8'(8'h20 + i), 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);

        // Read and write together on empty, then clear the error
        step(0, 1, 8'h5A, 1, 0);
        step(0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 1, 0);

        // Reset with data inside, then reuse
        for (int i = 0; i < 3; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
        step(1, 1, 8'h77, 1, 0);
        step(0, 1, 8'h33, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 0, 0);

        // Randomised traffic: write-heavy phase then read-heavy phase
        for (int i = 0; i < 300; i++) begin
            int wp;
            wp = (i < 150) ? 70 : 30;
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 99) < wp),
                 8'($urandom),
                 ($urandom_range(0, 99) < (100 - wp)),
                 ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
